// File: rtl/piso_rr_arbiter.sv
// piso_rr_arbiter: round-robin sharing of one PISO serializer among valid/ready word sources
module piso_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int CNTW      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           ser_valid,
  output logic [DATAWIDTH-1:0]           ser_data,
  input  logic                           ser_ready,
  input  logic                           sym_fire,
  input  logic                           ser_last,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           len_err,
  output logic [CNTW-1:0]                word_cnt
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = $clog2(DATAWIDTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SERIAL} state_t;

  state_t        state, state_n;
  logic [GW-1:0] rr_ptr, pick, idx;
  logic          found;
  logic [SW-1:0] sym_cnt;
  logic [SW:0]   sym_next;
  logic          accept, done;

  assign accept   = ser_valid & ser_ready;
  assign done     = (state == SERIAL) & sym_fire & ser_last;
  assign busy     = state != IDLE;
  assign sym_next = {1'b0, sym_cnt} + 1'b1;

  // Forward the granted source to the serializer only while loading
  always_comb begin
    ser_valid = (state == LOAD) & req_valid[grant_id];
    ser_data  = ser_valid ? req_data[int'(grant_id)*DATAWIDTH +: DATAWIDTH] : '0;
    req_ready = (state == LOAD) ? NUM_REQ'(ser_ready) << grant_id : '0;
  end

  // First valid requester scanning upward from the one after the last completed grant
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next state: a dropped request in LOAD abandons the grant without moving the pointer
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = found ? LOAD : IDLE;
      LOAD:    state_n = accept ? SERIAL : (!req_valid[grant_id] ? IDLE : LOAD);
      SERIAL:  state_n = done ? IDLE : SERIAL;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Grant, symbol counting, completion bookkeeping and the sticky length check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= GW'(NUM_REQ - 1);
      grant_id <= '0;
      sym_cnt  <= '0;
      len_err  <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (state == IDLE && found) grant_id <= pick;
      if (accept) sym_cnt <= '0;
      else if (state == SERIAL && sym_fire && sym_cnt != '1) sym_cnt <= sym_next[SW-1:0];
      if (done) begin
        rr_ptr   <= grant_id;
        word_cnt <= word_cnt + 1'b1;
        if (sym_next != (SW+1)'(DATAWIDTH)) len_err <= 1'b1;
      end
    end
  end
endmodule
